// File: rtl/kong_pkg.sv
// Shared encodings for the kong actor controller and related sprite logic.
package kong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } kong_state_e;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/kong_anim_counter.sv
// Animation frame divider: counts enabled ticks and steps through a wrapping frame index.
module kong_anim_counter #(
    parameter int ANI_DIV    = 8,
    parameter int ANI_FRAMES = 4,
    parameter int AS_W       = 2,
    parameter int AC_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [AC_W-1:0] anicnt,
    output logic [AS_W-1:0] animation_state
);

    if (ANI_DIV < 1 || (2 ** AC_W) < ANI_DIV) begin : g_bad_div
        $error("kong_anim_counter: ANI_DIV out of range for AC_W");
    end
    if (ANI_FRAMES < 2 || (2 ** AS_W) < ANI_FRAMES) begin : g_bad_frames
        $error("kong_anim_counter: ANI_FRAMES out of range for AS_W");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anicnt          <= '0;
            animation_state <= '0;
        end else if (en) begin
            if (anicnt == AC_W'(ANI_DIV - 1)) begin
                anicnt <= '0;
                if (animation_state == AS_W'(ANI_FRAMES - 1))
                    animation_state <= '0;
                else
                    animation_state <= animation_state + AS_W'(1);
            end else begin
                anicnt <= anicnt + AC_W'(1);
            end
        end
    end

endmodule

// File: rtl/kong_actor_ctrl.sv
// Enemy actor controller: patrols between two x bounds on frame ticks, with game-state FSM.
// Optional periodic barrel throw enabled by defining THROW_EN.
module kong_actor_ctrl
    import kong_pkg::*;
#(
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int X_INIT       = 100,
    parameter int Y_INIT       = 80,
    parameter int X_MIN        = 64,
    parameter int X_MAX        = 160,
    parameter int STEP         = 4,
    parameter int ANI_DIV      = 8,
    parameter int ANI_FRAMES   = 4,
    parameter int AS_W         = 2,
    parameter int AC_W         = 4,
    parameter int THROW_PERIOD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            over,
    input  logic            tick,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic [1:0]      state,
    output logic            dir,
    output logic [AS_W-1:0] animation_state,
    output logic [AC_W-1:0] anicnt,
    output logic            throw
);

    localparam int XE_W = X_W + 1;
    localparam logic [XE_W-1:0] STEP_E     = XE_W'(STEP);
    localparam logic [XE_W-1:0] MAX_E      = XE_W'(X_MAX);
    localparam logic [XE_W-1:0] MIN_STEP_E = XE_W'(X_MIN + STEP);

    if (X_MIN > X_INIT || X_INIT > X_MAX || X_MAX >= (2 ** X_W)) begin : g_bad_bounds
        $error("kong_actor_ctrl: patrol bounds inconsistent");
    end
    if (STEP < 1 || STEP > X_MAX - X_MIN) begin : g_bad_step
        $error("kong_actor_ctrl: STEP out of range");
    end
    if (THROW_PERIOD < 1) begin : g_bad_throw
        $error("kong_actor_ctrl: THROW_PERIOD must be >= 1");
    end

    kong_state_e state_q, state_n;
    logic [X_W-1:0] x_n;
    logic           dir_n;
    logic           step_en;
    logic [XE_W-1:0] x_ext, x_up, x_dn;

    assign state   = state_q;
    // over wins over a same-cycle tick, so a freezing cycle never moves the actor
    assign step_en = (state_q == ST_RUN) && tick && !over;
    assign x_ext   = {1'b0, x};
    assign x_up    = x_ext + STEP_E;
    assign x_dn    = x_ext - STEP_E;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (over)
                    state_n = ST_HALT;
                else if (start)
                    state_n = ST_RUN;
            end
            ST_RUN: begin
                if (over)
                    state_n = ST_HALT;
            end
            ST_HALT: state_n = ST_HALT;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        x_n   = x;
        dir_n = dir;
        if (step_en) begin
            if (dir == DIR_POS) begin
                if (x_up >= MAX_E) begin
                    x_n   = X_W'(X_MAX);
                    dir_n = DIR_NEG;
                end else begin
                    x_n = x_up[X_W-1:0];
                end
            end else begin
                if (x_ext <= MIN_STEP_E) begin
                    x_n   = X_W'(X_MIN);
                    dir_n = DIR_POS;
                end else begin
                    x_n = x_dn[X_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        y <= Y_W'(Y_INIT);
        if (rst) begin
            x   <= X_W'(X_INIT);
            dir <= DIR_POS;
        end else begin
            x   <= x_n;
            dir <= dir_n;
        end
    end

    kong_anim_counter #(
        .ANI_DIV    (ANI_DIV),
        .ANI_FRAMES (ANI_FRAMES),
        .AS_W       (AS_W),
        .AC_W       (AC_W)
    ) u_anim (
        .clk             (clk),
        .rst             (rst),
        .en              (step_en),
        .anicnt          (anicnt),
        .animation_state (animation_state)
    );

`ifdef THROW_EN
    localparam int TC_W = $clog2(THROW_PERIOD + 1);
    logic [TC_W-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            throw <= 1'b0;
        end else if (state_q != ST_HALT) begin
            throw <= 1'b0;
            if (step_en) begin
                if (tcnt == TC_W'(THROW_PERIOD - 1)) begin
                    tcnt  <= '0;
                    throw <= 1'b1;
                end else begin
                    tcnt <= tcnt + TC_W'(1);
                end
            end
        end
    end
`else
    assign throw = 1'b0;
`endif

endmodule

// File: doc/kong_actor_ctrl.md
Name: kong_actor_ctrl

Overview:
Parametrised successor to the single-sprite kong controller. It drives one enemy actor's screen position, patrol direction, game state and animation frame. The actor patrols horizontally between two bounds and advances motion and animation only on a per-frame strobe. It sits between the game-flow FSM (start/over) and the sprite renderer (x, y, animation_state).

Parameters:
X_W, 10, width of x coordinate
Y_W, 9, width of y coordinate
X_INIT, 100, x after reset
Y_INIT, 80, constant y (platform row)
X_MIN, 64, left patrol bound; requires X_MIN <= X_INIT <= X_MAX
X_MAX, 160, right patrol bound; requires X_MAX < 2**X_W
STEP, 4, pixels moved per tick; requires 1 <= STEP <= X_MAX-X_MIN
ANI_DIV, 8, ticks per animation frame; requires >= 1
ANI_FRAMES, 4, number of animation frames; requires >= 2
AS_W, 2, width of animation_state; requires 2**AS_W >= ANI_FRAMES
AC_W, 4, width of anicnt; requires 2**AC_W >= ANI_DIV
THROW_PERIOD, 32, ticks between throws (THROW_EN only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  level/pulse; begin patrol
over  in  1  level/pulse; game over, freeze actor
tick  in  1  one-cycle frame strobe
x  out  X_W  actor x position, registered
y  out  Y_W  actor y position, registered
state  out  2  0=IDLE, 1=RUN, 2=HALT
dir  out  1  0=moving +x, 1=moving -x
animation_state  out  AS_W  current animation frame
anicnt  out  AC_W  ticks elapsed within current frame
throw  out  1  one-cycle barrel-throw pulse

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. rst has priority over every other input.
- Reset values: state=IDLE, x=X_INIT, y=Y_INIT, dir=0, animation_state=0, anicnt=0, throw=0.
- All outputs are registered. Each update becomes visible the cycle after the qualifying input.
- IDLE:
  - over=1 -> HALT. over has priority over start.
  - else start=1 -> RUN.
  - tick is ignored, including a tick in the same cycle as start.
- RUN:
  - over=1 -> HALT. A simultaneous tick is discarded; no position or animation update that cycle.
  - start is ignored.
  - On tick with dir=0: if x+STEP >= X_MAX then x=X_MAX and dir=1, else x=x+STEP.
  - On tick with dir=1: if x <= X_MIN+STEP then x=X_MIN and dir=0, else x=x-STEP.
  - Sums and compares are computed at X_W+1 bits; no wrap-around.
  - On tick, animation: if anicnt==ANI_DIV-1 then anicnt=0 and animation_state advances (ANI_FRAMES-1 wraps to 0); else anicnt increments.
- HALT: all outputs are frozen and start/tick/over are ignored. Only rst leaves HALT.
- y is held at Y_INIT in every state.
- Reset mid-RUN returns all outputs to their reset values on the next edge; no partial update completes.

Optional Feature:
- Macro THROW_EN.
- Defined:
  - A tick counter runs only in RUN on non-discarded ticks.
  - On the THROW_PERIOD-th such tick, throw=1 for exactly one cycle, registered alongside the position update, and the counter restarts.
  - The counter clears on rst and holds in IDLE/HALT.
  - A throw pulse is never issued in the cycle entering HALT.
- Undefined: the throw port remains and is tied to 0; no counter logic is present.

Decomposition:
- Shared package/include kong_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2
  - direction constants DIR_POS=1'b0, DIR_NEG=1'b1
- One natural sub-module, kong_anim_counter: the anicnt/animation_state divider with ports clk, rst, en, anicnt, animation_state. It is parametrised by ANI_DIV, ANI_FRAMES, AS_W and AC_W, and is reusable by other sprites.

Test Plan (default parameters):
- Reset: rst=1 for 2 cycles -> x=100, y=80, state=0, dir=0, animation_state=0, anicnt=0, throw=0.
- Patrol: start pulse, then 15 ticks -> x=156 after 14th tick; x=160, dir=1 after 15th; x=156 after 16th. 25 further ticks -> x=64 with dir=0 after the 24th of them (160-4*24=64).
- Animation: start, then 8 ticks -> animation_state=1, anicnt=0. 32 ticks total -> animation_state=0, anicnt=0. tick in the same cycle as start -> no change.
- Over precedence: RUN with x=120, then over=1 and tick=1 in the same cycle -> state=2, x=120 unchanged. Later start and tick pulses -> no change. rst -> state=0, x=100.
- Reset mid-run: after 5 ticks (x=120, anicnt=5), rst=1 and tick=1 -> all outputs at reset values next cycle.
- THROW_EN: start, 32 ticks -> exactly one throw pulse, in the cycle after the 32nd tick; over at tick 31 -> no pulse ever.
